// File: rtl/conv_stream.sv
// conv_stream: streaming KxK signed 2-D convolution over an NxN raster-order
// pixel stream with stride S, ReLU option and OUT_W saturation.
//
// Ports:
//   clk          - clock, all state on rising edge
//   global_rst_n - asynchronous active-low reset
//   clr          - synchronous frame abort (wins over in_valid)
//   weight1      - packed signed weights, index i = row*K + col
//   relu_en      - clamp negative results to zero
//   in_valid     - pixel valid
//   in_ready     - pixel accepted when in_valid && in_ready
//   activation   - signed pixel, raster order
//   out_valid    - conv_op valid
//   out_ready    - downstream accepts
//   conv_op      - signed, saturated result
//   out_last     - final output of a frame
//   end_conv     - one-cycle pulse after the last pixel of a frame is accepted
module conv_stream #(
  parameter int DATA_W = 16,
  parameter int N      = 10,
  parameter int K      = 3,
  parameter int S      = 1,
  parameter int OUT_W  = 32
) (
  input  logic                       clk,
  input  logic                       global_rst_n,
  input  logic                       clr,
  input  logic [K*K*DATA_W-1:0]      weight1,
  input  logic                       relu_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          activation,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           conv_op,
  output logic                       out_last,
  output logic                       end_conv
);

  localparam int ACC_W  = 2*DATA_W + $clog2(K*K);
  localparam int KK     = K*K;
  localparam int PROD_W = 2*DATA_W;
  localparam int TAPS   = (K-1)*N + (K-1);
  localparam int CNT_W  = $clog2(N);
  localparam int PH_W   = (S > 1) ? $clog2(S) : 1;
  localparam int LASTQ  = (K-1) + S*((N-K)/S);

  localparam logic [CNT_W-1:0] C_FIRST = CNT_W'(K-1);
  localparam logic [CNT_W-1:0] C_END   = CNT_W'(N-1);
  localparam logic [CNT_W-1:0] C_LASTQ = CNT_W'(LASTQ);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(S-1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------- control
  logic w_stall, w_accept, w_qual, w_eof, w_lastq;

  logic [CNT_W-1:0] r_row, r_col;
  logic [PH_W-1:0]  r_rph, r_cph;

  logic r_v1, r_last1, r_relu1;
  logic r_v2, r_last2, r_end;
  logic [OUT_W-1:0] r_op;

  assign w_stall  = r_v2 && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && !w_stall && !clr;

  // r_rph/r_cph track (row-K+1)%S and (col-K+1)%S incrementally, so no divider.
  assign w_qual  = (r_row >= C_FIRST) && (r_col >= C_FIRST) &&
                   (r_rph == '0) && (r_cph == '0);
  assign w_eof   = (r_row == C_END) && (r_col == C_END);
  assign w_lastq = (r_row == C_LASTQ) && (r_col == C_LASTQ);

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_rph <= '0;
      r_cph <= '0;
    end else if (clr) begin
      r_row <= '0;
      r_col <= '0;
      r_rph <= '0;
      r_cph <= '0;
    end else if (w_accept) begin
      if (r_col == C_END) begin
        r_col <= '0;
        r_cph <= '0;
        if (r_row == C_END) begin
          r_row <= '0;
          r_rph <= '0;
        end else begin
          r_row <= r_row + 1'b1;
          if (r_row >= C_FIRST)
            r_rph <= (r_rph == PH_MAX) ? '0 : r_rph + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
        if (r_col >= C_FIRST)
          r_cph <= (r_cph == PH_MAX) ? '0 : r_cph + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ line buffers/window
  // One delay line holds K-1 full rows plus the K-1 most recent pixels of the
  // current row; together with the incoming pixel this forms the KxK window.
  logic [DATA_W-1:0] r_taps [TAPS];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_taps[0] <= activation;
      for (int unsigned j = 1; j < TAPS; j++)
        r_taps[j] <= r_taps[j-1];
    end
  end

  logic signed [DATA_W-1:0] w_win [KK];
  logic signed [DATA_W-1:0] w_wt  [KK];

  for (genvar gi = 0; gi < KK; gi++) begin : g_win
    assign w_wt[gi] = weight1[DATA_W*gi +: DATA_W];
    if (gi == KK-1) begin : g_cur
      assign w_win[gi] = activation;
    end else begin : g_tap
      // window[i] lies (K-1-i/K) rows and (K-1-i%K) columns behind the input
      assign w_win[gi] = r_taps[(K-1-gi/K)*N + (K-1-gi%K) - 1];
    end
  end

  // ---------------------------------------------------- stage 1: products
  logic signed [PROD_W-1:0] r_prod [KK];

  always_ff @(posedge clk) begin
    if (w_accept && w_qual) begin
      for (int unsigned i = 0; i < KK; i++)
        r_prod[i] <= w_win[i] * w_wt[i];
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_relu1 <= 1'b0;
    end else if (clr) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
    end else if (!w_stall) begin
      r_v1    <= w_accept && w_qual;
      r_last1 <= w_accept && w_qual && w_lastq;
      r_relu1 <= relu_en;
    end
  end

  // ------------------------------------------------- stage 2: sum and clamp
  logic signed [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0]        w_res;

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < KK; i++)
      w_sum = w_sum + ACC_W'(r_prod[i]);
  end

  always_comb begin
    w_res = w_sum[OUT_W-1:0];
    if (r_relu1 && (w_sum < 0))
      w_res = '0;
    else if (w_sum > SAT_MAX)
      w_res = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_sum < SAT_MIN)
      w_res = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_op    <= '0;
      r_end   <= 1'b0;
    end else if (clr) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_end <= w_accept && w_eof;
      if (!w_stall) begin
        r_v2    <= r_v1;
        r_last2 <= r_last1;
        if (r_v1)
          r_op <= w_res;
      end
    end
  end

  assign out_valid = r_v2;
  assign out_last  = r_last2;
  assign conv_op   = r_op;
  assign end_conv  = r_end;

endmodule
